// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states
// and the datapath mux / ALU select codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_ADDI  = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b110;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_RS     = 2'd3;

    // States that hold a memory request open and are guarded by the wait timer.
    function automatic logic is_mem_wait(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Counts cycles a memory request has been stalled; flags the cycle in which
// another stalled cycle would reach the limit.
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int W            = $clog2(MEM_WAIT_MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != W'(MEM_WAIT_MAX))) begin
            count <= count + 1'b1;
        end
    end

    // A ready response in the limit cycle is a success, so inc gates the flag.
    assign expired = inc && (count == W'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// with a MemReady handshake, a memory wait timeout trap and illegal-opcode flag.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4, load IR on MemReady
// DECODE | precompute branch target, dispatch on opcode
// MEMADR | compute lw/sw effective address
// MEMRD  | data read, wait for MemReady
// MEMWB  | write loaded data to rt
// MEMWR  | data write, wait for MemReady
// REXEC  | R-type ALU operation
// RWB    | write ALU result to rd
// IEXEC  | addi/andi ALU operation
// IWB    | write ALU result to rt
// BRANCH | beq/bne compare and conditional PC load
// JUMP   | j
// JAL    | jal: PC load plus PC write-back to $ra
// JR     | jump to rs
// TRAP   | memory timeout, held until reset
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int ALUOP_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCEn,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWr,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemToReg,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic [ALUOP_W-1:0] Aluop,
    output logic [1:0]         PCSource,
    output logic               IllegalOp,
    output logic               Trap,
    output logic [3:0]         State
);

    state_t state_q;
    state_t state_d;
    logic   trap_q;
    logic   pc_write;
    logic   branch_taken;
    logic   timer_clr;
    logic   timer_inc;
    logic   timer_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) begin
                trap_q <= 1'b1;
            end
        end
    end

    // Clearing on every state change gives each wait state a fresh count on entry.
    assign timer_clr = (state_d != state_q);
    assign timer_inc = is_mem_wait(state_q) && !MemReady;

    mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b0;
        branch_taken = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWr        = 1'b0;
        RegDst       = DST_RT;
        MemToReg     = WB_ALUOUT;
        AluSrcA      = 1'b0;
        AluSrcB      = SRCB_RT;
        Aluop        = ALUOP_W'(ALU_FUNCT);
        PCSource     = PCS_ALU;
        IllegalOp    = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                AluSrcB = SRCB_FOUR;
                Aluop   = ALUOP_W'(ALU_ADD);
                if (MemReady) begin
                    IRWrite  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timer_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                AluSrcB = SRCB_IMM_SH;
                Aluop   = ALUOP_W'(ALU_ADD);
                case (Op)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_RTYPE:         state_d = (Funct == FUNCT_JR) ? S_JR : S_REXEC;
                    OP_ADDI, OP_ANDI: state_d = S_IEXEC;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    default: begin
                        IllegalOp = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
                Aluop   = ALUOP_W'(ALU_ADD);
                state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) begin
                    state_d = S_MEMWB;
                end else if (timer_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_MEMWB: begin
                RegWr    = 1'b1;
                MemToReg = WB_MDR;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    state_d = S_FETCH;
                end else if (timer_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_REXEC: begin
                AluSrcA = 1'b1;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWr   = 1'b1;
                RegDst  = DST_RD;
                state_d = S_FETCH;
            end
            S_IEXEC: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
                Aluop   = (Op == OP_ANDI) ? ALUOP_W'(ALU_AND) : ALUOP_W'(ALU_ADDI);
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWr   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                AluSrcA      = 1'b1;
                Aluop        = ALUOP_W'(ALU_SUB);
                PCSource     = PCS_ALUOUT;
                branch_taken = (Op == OP_BNE) ? !Zero : Zero;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                PCSource = PCS_JUMP;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                PCSource = PCS_JUMP;
                pc_write = 1'b1;
                RegWr    = 1'b1;
                RegDst   = DST_RA;
                MemToReg = WB_PC;
                state_d  = S_FETCH;
            end
            S_JR: begin
                PCSource = PCS_RS;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset silences every strobe in the cycle it is asserted.
        if (rst) begin
            pc_write     = 1'b0;
            branch_taken = 1'b0;
            IorD         = 1'b0;
            MemRead      = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            RegWr        = 1'b0;
            RegDst       = '0;
            MemToReg     = '0;
            AluSrcA      = 1'b0;
            AluSrcB      = '0;
            Aluop        = '0;
            PCSource     = '0;
            IllegalOp    = 1'b0;
        end
    end

    assign PCEn  = pc_write || branch_taken;
    assign Trap  = trap_q && !rst;
    assign State = rst ? 4'd0 : 4'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed vector bench for multicycle_control_unit: per-cycle table of inputs
// and expected outputs, plus sequences for wait-limit, trap and reset corners.
module tb_multicycle_control_unit;

    logic       clk;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegWr;
    logic [1:0] RegDst, MemToReg, AluSrcB, PCSource;
    logic       AluSrcA, IllegalOp, Trap;
    logic [2:0] Aluop;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [19:0] o;
    } vec_t;

    vec_t vecs[$];

    multicycle_control_unit #(.MEM_WAIT_MAX(15), .ALUOP_W(3)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWr(RegWr), .RegDst(RegDst), .MemToReg(MemToReg), .AluSrcA(AluSrcA),
        .AluSrcB(AluSrcB), .Aluop(Aluop), .PCSource(PCSource), .IllegalOp(IllegalOp),
        .Trap(Trap), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] JJ = 6'b000010, JAL = 6'b000011, ADDI = 6'b001000, ANDI = 6'b001100;
    localparam logic [5:0] RT = 6'b000000, BAD = 6'b111111;

    function automatic logic [19:0] pack(int pcen, int iord, int mrd, int mwr, int irw, int rw,
                                         int rd, int mtr, int sa, int sb, int alu, int pcs,
                                         int ill, int trap);
        return {1'(pcen), 1'(iord), 1'(mrd), 1'(mwr), 1'(irw), 1'(rw), 2'(rd), 2'(mtr),
                1'(sa), 2'(sb), 3'(alu), 2'(pcs), 1'(ill), 1'(trap)};
    endfunction

    task automatic add(int r, logic [5:0] op, logic [5:0] fn, int z, int mr, int st,
                       int pcen, int iord, int mrd, int mwr, int irw, int rw, int rd, int mtr,
                       int sa, int sb, int alu, int pcs, int ill, int trap);
        vec_t v;
        v.rst = 1'(r); v.op = op; v.funct = fn; v.zero = 1'(z); v.mr = 1'(mr); v.st = 4'(st);
        v.o = pack(pcen, iord, mrd, mwr, irw, rw, rd, mtr, sa, sb, alu, pcs, ill, trap);
        vecs.push_back(v);
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic [5:0] op, logic [5:0] fn, logic z, logic mr);
        #1;
        rst = r; Op = op; Funct = fn; Zero = z; MemReady = mr;
        @(negedge clk);
    endtask

    function automatic logic [19:0] dut_o();
        return {PCEn, IorD, MemRead, MemWrite, IRWrite, RegWr, RegDst, MemToReg,
                AluSrcA, AluSrcB, Aluop, PCSource, IllegalOp, Trap};
    endfunction

    initial begin
        rst = 1'b1; Op = LW; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b1;

        // reset, then lw with MemReady always 1
        add(1, LW,   0, 0, 1,  0,  0,0,0,0,0,0,0,0, 0,0,0,0, 0,0);
        add(1, LW,   0, 0, 1,  0,  0,0,0,0,0,0,0,0, 0,0,0,0, 0,0);
        add(0, LW,   0, 0, 1,  0,  1,0,1,0,1,0,0,0, 0,1,1,0, 0,0);
        add(0, LW,   0, 0, 1,  1,  0,0,0,0,0,0,0,0, 0,3,1,0, 0,0);
        add(0, LW,   0, 0, 1,  2,  0,0,0,0,0,0,0,0, 1,2,1,0, 0,0);
        add(0, LW,   0, 0, 1,  3,  0,1,1,0,0,0,0,0, 0,0,0,0, 0,0);
        add(0, LW,   0, 0, 1,  4,  0,0,0,0,0,1,0,1, 0,0,0,0, 0,0);
        // sw with three stalled cycles in MEMWR
        add(0, SW,   0, 0, 1,  0,  1,0,1,0,1,0,0,0, 0,1,1,0, 0,0);
        add(0, SW,   0, 0, 1,  1,  0,0,0,0,0,0,0,0, 0,3,1,0, 0,0);
        add(0, SW,   0, 0, 1,  2,  0,0,0,0,0,0,0,0, 1,2,1,0, 0,0);
        add(0, SW,   0, 0, 0,  5,  0,1,0,1,0,0,0,0, 0,0,0,0, 0,0);
        add(0, SW,   0, 0, 0,  5,  0,1,0,1,0,0,0,0, 0,0,0,0, 0,0);
        add(0, SW,   0, 0, 0,  5,  0,1,0,1,0,0,0,0, 0,0,0,0, 0,0);
        add(0, SW,   0, 0, 1,  5,  0,1,0,1,0,0,0,0, 0,0,0,0, 0,0);
        // beq taken, bne not taken, bne taken
        add(0, BEQ,  0, 1, 1,  0,  1,0,1,0,1,0,0,0, 0,1,1,0, 0,0);
        add(0, BEQ,  0, 1, 1,  1,  0,0,0,0,0,0,0,0, 0,3,1,0, 0,0);
        add(0, BEQ,  0, 1, 1, 10,  1,0,0,0,0,0,0,0, 1,0,6,1, 0,0);
        add(0, BNE,  0, 1, 1,  0,  1,0,1,0,1,0,0,0, 0,1,1,0, 0,0);
        add(0, BNE,  0, 1, 1,  1,  0,0,0,0,0,0,0,0, 0,3,1,0, 0,0);
        add(0, BNE,  0, 1, 1, 10,  0,0,0,0,0,0,0,0, 1,0,6,1, 0,0);
        add(0, BNE,  0, 0, 1,  0,  1,0,1,0,1,0,0,0, 0,1,1,0, 0,0);
        add(0, BNE,  0, 0, 1,  1,  0,0,0,0,0,0,0,0, 0,3,1,0, 0,0);
        add(0, BNE,  0, 0, 1, 10,  1,0,0,0,0,0,0,0, 1,0,6,1, 0,0);
        // jal
        add(0, JAL,  0, 0, 1,  0,  1,0,1,0,1,0,0,0, 0,1,1,0, 0,0);
        add(0, JAL,  0, 0, 1,  1,  0,0,0,0,0,0,0,0, 0,3,1,0, 0,0);
        add(0, JAL,  0, 0, 1, 12,  1,0,0,0,0,1,2,2, 0,0,0,2, 0,0);
        // illegal opcode
        add(0, BAD,  0, 0, 1,  0,  1,0,1,0,1,0,0,0, 0,1,1,0, 0,0);
        add(0, BAD,  0, 0, 1,  1,  0,0,0,0,0,0,0,0, 0,3,1,0, 1,0);
        // addi
        add(0, ADDI, 0, 0, 1,  0,  1,0,1,0,1,0,0,0, 0,1,1,0, 0,0);
        add(0, ADDI, 0, 0, 1,  1,  0,0,0,0,0,0,0,0, 0,3,1,0, 0,0);
        add(0, ADDI, 0, 0, 1,  8,  0,0,0,0,0,0,0,0, 1,2,2,0, 0,0);
        add(0, ADDI, 0, 0, 1,  9,  0,0,0,0,0,1,0,0, 0,0,0,0, 0,0);
        // jr
        add(0, RT, 6'b001000, 0, 1,  0,  1,0,1,0,1,0,0,0, 0,1,1,0, 0,0);
        add(0, RT, 6'b001000, 0, 1,  1,  0,0,0,0,0,0,0,0, 0,3,1,0, 0,0);
        add(0, RT, 6'b001000, 0, 1, 13,  1,0,0,0,0,0,0,0, 0,0,0,3, 0,0);
        // R-type add
        add(0, RT, 6'b100000, 0, 1,  0,  1,0,1,0,1,0,0,0, 0,1,1,0, 0,0);
        add(0, RT, 6'b100000, 0, 1,  1,  0,0,0,0,0,0,0,0, 0,3,1,0, 0,0);
        add(0, RT, 6'b100000, 0, 1,  6,  0,0,0,0,0,0,0,0, 1,0,0,0, 0,0);
        add(0, RT, 6'b100000, 0, 1,  7,  0,0,0,0,0,1,1,0, 0,0,0,0, 0,0);
        // j
        add(0, JJ,   0, 0, 1,  0,  1,0,1,0,1,0,0,0, 0,1,1,0, 0,0);
        add(0, JJ,   0, 0, 1,  1,  0,0,0,0,0,0,0,0, 0,3,1,0, 0,0);
        add(0, JJ,   0, 0, 1, 11,  1,0,0,0,0,0,0,0, 0,0,0,2, 0,0);
        // andi with one stalled fetch cycle
        add(0, ANDI, 0, 0, 0,  0,  0,0,1,0,0,0,0,0, 0,1,1,0, 0,0);
        add(0, ANDI, 0, 0, 1,  0,  1,0,1,0,1,0,0,0, 0,1,1,0, 0,0);
        add(0, ANDI, 0, 0, 1,  1,  0,0,0,0,0,0,0,0, 0,3,1,0, 0,0);
        add(0, ANDI, 0, 0, 1,  8,  0,0,0,0,0,0,0,0, 1,2,3,0, 0,0);
        add(0, ANDI, 0, 0, 1,  9,  0,0,0,0,0,1,0,0, 0,0,0,0, 0,0);

        @(posedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].mr);
            chk($sformatf("vec%0d State", i), int'(State), int'(vecs[i].st));
            checks++;
            if (dut_o() !== vecs[i].o) begin
                errors++;
                $display("FAIL vec%0d outputs: got %05h expected %05h", i, dut_o(), vecs[i].o);
            end
            @(posedge clk);
        end

        // MemReady arriving in the limit cycle is a success
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, BAD, 6'd0, 1'b0, 1'b0);
            chk($sformatf("limit wait%0d State", i), int'(State), 0);
            @(posedge clk);
        end
        drive(1'b0, BAD, 6'd0, 1'b0, 1'b1);
        chk("limit ready IRWrite", int'(IRWrite), 1);
        chk("limit ready State", int'(State), 0);
        @(posedge clk);
        drive(1'b0, BAD, 6'd0, 1'b0, 1'b1);
        chk("limit decode State", int'(State), 1);
        chk("limit decode Trap", int'(Trap), 0);
        @(posedge clk);

        // MemReady stuck low: 15 fetch cycles, then TRAP
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, BAD, 6'd0, 1'b0, 1'b0);
            chk($sformatf("stall%0d State", i), int'(State), 0);
            chk($sformatf("stall%0d Trap", i), int'(Trap), 0);
            @(posedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, BAD, 6'd0, 1'b0, 1'(i % 2));
            chk($sformatf("trap%0d State", i), int'(State), 14);
            chk($sformatf("trap%0d Trap", i), int'(Trap), 1);
            chk($sformatf("trap%0d MemRead", i), int'(MemRead), 0);
            @(posedge clk);
        end
        drive(1'b1, LW, 6'd0, 1'b0, 1'b0);
        chk("trap rst State", int'(State), 0);
        chk("trap rst Trap", int'(Trap), 0);
        @(posedge clk);
        drive(1'b0, SW, 6'd0, 1'b0, 1'b0);
        chk("post rst State", int'(State), 0);
        chk("post rst Trap", int'(Trap), 0);
        chk("post rst MemRead", int'(MemRead), 1);
        @(posedge clk);

        // reset in the middle of a store
        drive(1'b0, SW, 6'd0, 1'b0, 1'b1);
        chk("abort fetch IRWrite", int'(IRWrite), 1);
        @(posedge clk);
        drive(1'b0, SW, 6'd0, 1'b0, 1'b1);
        @(posedge clk);
        drive(1'b0, SW, 6'd0, 1'b0, 1'b1);
        chk("abort memadr State", int'(State), 2);
        @(posedge clk);
        drive(1'b0, SW, 6'd0, 1'b0, 1'b0);
        chk("abort memwr MemWrite", int'(MemWrite), 1);
        @(posedge clk);
        drive(1'b1, SW, 6'd0, 1'b0, 1'b0);
        chk("abort rst MemWrite", int'(MemWrite), 0);
        chk("abort rst State", int'(State), 0);
        @(posedge clk);
        drive(1'b0, SW, 6'd0, 1'b0, 1'b0);
        chk("abort resume State", int'(State), 0);
        chk("abort resume MemRead", int'(MemRead), 1);
        chk("abort resume MemWrite", int'(MemWrite), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle MIPS control FSM that drives the shared-datapath processor: it sequences fetch, decode, execute, memory and write-back per instruction instead of decoding in one cycle. It extends the instruction set to bne, j, jal and jr, and adds a MemReady handshake with a wait timeout. An illegal-opcode flag is also provided. It sits between the instruction register and the datapath muxes, ALU control and the register file.

## Interface
- MEM_WAIT_MAX, 15: maximum cycles a memory access waits for MemReady before trapping (1..255).
- ALUOP_W, 3: width of Aluop.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- Op  in  6  opcode from the instruction register.
- Funct  in  6  function field, used only to detect jr (001000).
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current read or write this cycle.
- PCEn  out  1  PC load enable. It is the OR of PCWrite and the resolved branch condition.
- IorD  out  1  memory address select: 0 PC, 1 AluOut.
- MemRead / MemWrite  out  1 each  memory strobes, held until MemReady.
- IRWrite  out  1  instruction register load.
- RegWr  out  1  register file write.
- RegDst  out  2  destination select: 0 rt, 1 rd, 2 $ra.
- MemToReg  out  2  write-back data select: 0 AluOut, 1 MDR, 2 PC.
- AluSrcA  out  1  ALU A operand: 0 PC, 1 rs.
- AluSrcB  out  2  ALU B operand: 0 rt, 1 constant 4, 2 sign-extended imm, 3 imm<<2.
- Aluop  out  ALUOP_W  ALU operation: 000 R-type/funct, 001 add, 010 addi-add, 011 and, 110 sub.
- PCSource  out  2  next-PC select: 0 ALU, 1 AluOut, 2 jump target, 3 rs.
- IllegalOp  out  1  one-cycle pulse in DECODE on an unknown opcode.
- Trap  out  1  sticky memory-timeout flag; cleared only by rst.
- State  out  4  current state code, for debug.

## Operation
- States, with their codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, IEXEC 8, IWB 9, BRANCH 10, JUMP 11, JAL 12, JR 13, TRAP 14.
- Outputs not listed for a state are 0.
- FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=1, Aluop=001, PCSource=0.
  - IRWrite and PCEn assert only in the cycle MemReady=1; the FSM then goes to DECODE.
- DECODE: AluSrcA=0, AluSrcB=3, Aluop=001, which precomputes the branch target.
- Dispatch from DECODE:
  - lw (100011) and sw (101011) go to MEMADR.
  - Op 000000 goes to JR when Funct=001000, otherwise to REXEC.
  - addi (001000) and andi (001100) go to IEXEC.
  - beq (000100) and bne (000101) go to BRANCH.
  - j (000010) goes to JUMP; jal (000011) goes to JAL.
  - Any other opcode pulses IllegalOp and returns to FETCH (the instruction is skipped).
- MEMADR: AluSrcA=1, AluSrcB=2, Aluop=001. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: RegWr=1, RegDst=0, MemToReg=1. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Goes to FETCH on MemReady. RegWr stays 0.
- REXEC: AluSrcA=1, AluSrcB=0, Aluop=000. Goes to RWB, which asserts RegWr=1, RegDst=1, MemToReg=0.
- IEXEC: AluSrcA=1, AluSrcB=2, Aluop=010 for addi or 011 for andi. Goes to IWB, which asserts RegWr=1, RegDst=0, MemToReg=0.
- BRANCH: AluSrcA=1, AluSrcB=0, Aluop=110, PCSource=1.
  - PCEn = Zero for beq, ~Zero for bne.
  - Goes to FETCH.
- JUMP: PCSource=2, PCEn=1.
- JAL: PCSource=2, PCEn=1, RegWr=1, RegDst=2, MemToReg=2.
- JR: PCSource=3, PCEn=1.
- JUMP, JAL and JR all go to FETCH.
- Memory wait:
  - A counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle MemReady=0.
  - If it reaches MEM_WAIT_MAX without MemReady, the FSM goes to TRAP and Trap sets.
  - MemReady in the same cycle the count reaches the limit counts as success.
- TRAP: all strobes 0; the FSM stays there until rst.

## Timing
- Reset:
  - While rst=1, every output is forced to 0 and State reads 0.
  - The state register loads FETCH and the counter and Trap clear on the rst edge.
  - The first FETCH strobes appear in the cycle after rst falls.
- Cycles per instruction with zero memory wait (MemReady=1 on first request):
  - R-type, addi, andi, sw: 4.
  - lw: 5.
  - beq, bne, j, jal, jr: 3.
- Each memory access adds W cycles, where W is the number of cycles MemReady is low.
- Outputs depend on the state only, except IRWrite and PCEn, which also depend on MemReady and Zero (Mealy).
- rst asserted mid-instruction or in TRAP aborts it; no write strobe occurs in the reset cycle.
- MemReady while no access is pending is ignored.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode constants and FUNCT_JR;
  - the state enum;
  - the Aluop, RegDst, MemToReg, AluSrcB and PCSource encodings.
- Sub-module mem_wait_timer: a parametrised counter with clear, increment and expired outputs, width $clog2(MEM_WAIT_MAX+1).

## Test plan
- rst high for 2 cycles, then lw with MemReady always 1:
  - States run 0,1,2,3,4,0.
  - RegWr=1, MemToReg=1 only in state 4.
  - Instruction takes 5 cycles.
- sw with MemReady held low 3 cycles in MEMWR:
  - MemWrite held 4 cycles.
  - RegWr never 1.
  - Return to FETCH after MemReady.
- beq, then bne, each with Zero=1:
  - PCEn=1 in the beq BRANCH cycle and 0 in the bne BRANCH cycle.
  - PCSource=1 in both.
- jal:
  - RegDst=2, MemToReg=2, RegWr=1, PCEn=1, PCSource=2 in one cycle.
  - Back to FETCH.
- Op=111111:
  - IllegalOp pulses exactly once in DECODE.
  - Next state FETCH; no write strobes.
- MemReady stuck low in FETCH, MEM_WAIT_MAX=15:
  - Trap sets after 15 cycles; State=14 holds.
  - rst returns to FETCH with Trap=0.
